// File: rtl/pll_scan_pkg.sv
// Shared types and helpers for the PLL scan-chain reconfiguration responder.
package pll_scan_pkg;

   localparam int SCAN_BITS_CIII = 144;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LOAD_TAIL,
      S_SHIFT,
      S_UPDATE,
      S_WAIT_DONE,
      S_ARESET
   } scan_state_t;

   // Ceiling log2, evaluated at elaboration time for counter widths.
   function automatic int clog2(input int value);
      int width;
      int span;
      width = 0;
      span  = 1;
      while (span < value) begin
         span  = span * 2;
         width = width + 1;
      end
      return width;
   endfunction

endpackage

// File: rtl/pll_scan_shifter.sv
// Serialises the shadow image onto the PLL scan port at clk/2, then runs one
// extra scanclk period with the enable low so the update strobe is clocked in.
module pll_scan_shifter
   import pll_scan_pkg::*;
#(
   parameter int SCAN_BITS = SCAN_BITS_CIII
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [SCAN_BITS-1:0] shadow_i,
   output logic                 scanclk_o,
   output logic                 scanclkena_o,
   output logic                 scandata_o,
   output logic                 done_o
);
   localparam int            CW       = clog2(SCAN_BITS + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(SCAN_BITS - 1);
   localparam logic [CW-1:0] UPD_SLOT = CW'(SCAN_BITS);

   logic          active_q, active_d;
   logic          phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_nxt;
   logic          sclk_q, sclk_d;
   logic          ena_q, ena_d;
   logic          sdata_q, sdata_d;
   logic          done_q, done_d;

   // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
   always_comb begin
      active_d = active_q;
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      sclk_d   = 1'b0;
      ena_d    = ena_q;
      sdata_d  = sdata_q;
      done_d   = 1'b0;
      cnt_nxt  = cnt_q + 1'b1;
      if (start_i) begin
         active_d = 1'b1;
         phase_d  = 1'b0;
         cnt_d    = '0;
         ena_d    = 1'b1;
         sdata_d  = shadow_i[0];
      end else if (active_q) begin
         if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
            // Lines done up with the last bit's rising half so the update strobe follows directly.
            done_d  = (cnt_q == LAST_BIT);
         end else begin
            phase_d = 1'b0;
            if (cnt_q == UPD_SLOT) begin
               active_d = 1'b0;
               ena_d    = 1'b0;
               sdata_d  = 1'b0;
            end else begin
               cnt_d = cnt_nxt;
               if (cnt_nxt == UPD_SLOT) begin
                  ena_d   = 1'b0;
                  sdata_d = 1'b0;
               end else begin
                  sdata_d = shadow_i[cnt_nxt];
               end
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         active_q <= 1'b0;
         phase_q  <= 1'b0;
         cnt_q    <= '0;
         sclk_q   <= 1'b0;
         ena_q    <= 1'b0;
         sdata_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         sclk_q   <= sclk_d;
         ena_q    <= ena_d;
         sdata_q  <= sdata_d;
         done_q   <= done_d;
      end
   end

   assign scanclk_o    = sclk_q;
   assign scanclkena_o = ena_q;
   assign scandata_o   = sdata_q;
   assign done_o       = done_q;

endmodule

// File: rtl/pll_scan_loader.sv
// PLL reconfiguration responder: fetches a scan image from ROM into a shadow
// register, shifts it into the PLL, strobes configupdate and resets the PLL.
module pll_scan_loader
   import pll_scan_pkg::*;
#(
   parameter int SCAN_BITS     = SCAN_BITS_CIII,
   parameter int ROM_AW        = 8,
   parameter int ARESET_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              write_from_rom_i,
   input  logic              reconfig_i,
   output logic              busy_o,
   output logic [ROM_AW-1:0] rom_address_o,
   output logic              write_rom_ena_o,
   input  logic              rom_data_i,
   output logic              pll_scanclk_o,
   output logic              pll_scanclkena_o,
   output logic              pll_scandata_o,
   output logic              pll_configupdate_o,
   input  logic              pll_scandone_i,
   output logic              pll_areset_o
);
   localparam logic [ROM_AW-1:0] ADDR_LAST   = ROM_AW'(SCAN_BITS - 1);
   localparam logic [3:0]        ARESET_LAST = 4'(ARESET_CYCLES - 1);

   scan_state_t          state_q, state_d;
   logic                 busy_q, busy_d;
   logic [ROM_AW-1:0]    addr_q, addr_d;
   logic                 rden_q, rden_d;
   logic                 cfg_q, cfg_d;
   logic                 areset_q, areset_d;
   logic [3:0]           tmr_q, tmr_d;
   logic                 rd_valid_q;
   logic [ROM_AW-1:0]    cap_addr_q;
   logic                 sd_meta_q, sd_sync_q;
   logic [SCAN_BITS-1:0] shadow_q;
   logic                 shift_start;
   logic                 shift_done;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Requests only count in IDLE; write_from_rom wins a same-cycle collision.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (write_from_rom_i) state_d = S_LOAD;
            else if (reconfig_i)  state_d = S_SHIFT;
         end
         S_LOAD:      if (addr_q == ADDR_LAST)  state_d = S_LOAD_TAIL;
         S_LOAD_TAIL: state_d = S_IDLE;
         S_SHIFT:     if (shift_done)           state_d = S_UPDATE;
         S_UPDATE:    if (tmr_q == 4'd1)        state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (sd_sync_q)            state_d = S_ARESET;
         S_ARESET:    if (tmr_q == ARESET_LAST) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they switch on the accepting edge.
   always_comb begin
      busy_d      = (state_d != S_IDLE);
      rden_d      = (state_d == S_LOAD);
      cfg_d       = (state_d == S_UPDATE);
      areset_d    = (state_d == S_ARESET);
      shift_start = (state_q == S_IDLE) && (state_d == S_SHIFT);
      addr_d      = addr_q;
      if (state_q == S_IDLE && state_d == S_LOAD)      addr_d = '0;
      else if (state_q == S_LOAD && state_d == S_LOAD) addr_d = addr_q + 1'b1;
      tmr_d = (state_d == state_q) ? tmr_q + 1'b1 : '0;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         busy_q     <= 1'b0;
         addr_q     <= '0;
         rden_q     <= 1'b0;
         cfg_q      <= 1'b0;
         areset_q   <= 1'b0;
         tmr_q      <= '0;
         rd_valid_q <= 1'b0;
         cap_addr_q <= '0;
         sd_meta_q  <= 1'b0;
         sd_sync_q  <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         addr_q     <= addr_d;
         rden_q     <= rden_d;
         cfg_q      <= cfg_d;
         areset_q   <= areset_d;
         tmr_q      <= tmr_d;
         rd_valid_q <= rden_q;
         cap_addr_q <= addr_q;
         sd_meta_q  <= pll_scandone_i;
         sd_sync_q  <= sd_meta_q;
      end
   end

   // NOTE: the shadow array has no reset; it is only read after a load has filled it.
   always_ff @(posedge clk_i) begin
      if (rd_valid_q) shadow_q[cap_addr_q] <= rom_data_i;
   end

   pll_scan_shifter #(
      .SCAN_BITS (SCAN_BITS)
   ) u_shifter (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .start_i      (shift_start),
      .shadow_i     (shadow_q),
      .scanclk_o    (pll_scanclk_o),
      .scanclkena_o (pll_scanclkena_o),
      .scandata_o   (pll_scandata_o),
      .done_o       (shift_done)
   );

   assign busy_o             = busy_q;
   assign rom_address_o      = addr_q;
   assign write_rom_ena_o    = rden_q;
   assign pll_configupdate_o = cfg_q;
   assign pll_areset_o       = areset_q;

endmodule

// File: tb/tb_pll_scan_loader.sv
// Self-checking bench for pll_scan_loader: ROM model, scan-bit scoreboard,
// request vector table and hand-written timing / reset sequences.
module tb_pll_scan_loader;
   import pll_scan_pkg::*;

   localparam int SCAN_BITS     = 144;
   localparam int ROM_AW        = 8;
   localparam int ARESET_CYCLES = 2;

   logic              clk_i = 1'b0;
   logic              reset_i = 1'b1;
   logic              write_from_rom_i = 1'b0;
   logic              reconfig_i = 1'b0;
   logic              rom_data_i = 1'b0;
   logic              pll_scandone_i = 1'b0;
   logic              busy_o;
   logic [ROM_AW-1:0] rom_address_o;
   logic              write_rom_ena_o;
   logic              pll_scanclk_o;
   logic              pll_scanclkena_o;
   logic              pll_scandata_o;
   logic              pll_configupdate_o;
   logic              pll_areset_o;

   pll_scan_loader #(
      .SCAN_BITS     (SCAN_BITS),
      .ROM_AW        (ROM_AW),
      .ARESET_CYCLES (ARESET_CYCLES)
   ) dut (
      .clk_i              (clk_i),
      .reset_i            (reset_i),
      .write_from_rom_i   (write_from_rom_i),
      .reconfig_i         (reconfig_i),
      .busy_o             (busy_o),
      .rom_address_o      (rom_address_o),
      .write_rom_ena_o    (write_rom_ena_o),
      .rom_data_i         (rom_data_i),
      .pll_scanclk_o      (pll_scanclk_o),
      .pll_scanclkena_o   (pll_scanclkena_o),
      .pll_scandata_o     (pll_scandata_o),
      .pll_configupdate_o (pll_configupdate_o),
      .pll_scandone_i     (pll_scandone_i),
      .pll_areset_o       (pll_areset_o)
   );

   always #10 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int checks = 0;
   int fails  = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic logic pat(input int a);
      return a[0] ^ a[3];
   endfunction

   // ROM with one cycle of read latency.
   always @(posedge clk_i) begin
      if (write_rom_ena_o) rom_data_i <= pat(int'(rom_address_o));
   end

   bit                exp_q[$];
   int                rise_cnt = 0;
   int                pop_cnt = 0;
   int                rden_cnt = 0;
   int                addr_err = 0;
   int                cfg_cnt = 0;
   int                cfg_ena_err = 0;
   logic              prev_sclk = 1'b0;
   logic              prev_rden = 1'b0;
   logic [ROM_AW-1:0] addr_exp = '0;

   // Monitor samples on the falling edge, away from the DUT's active edge.
   always @(negedge clk_i) begin
      if (write_rom_ena_o === 1'b1) begin
         addr_exp = prev_rden ? addr_exp + 1'b1 : '0;
         if (rom_address_o !== addr_exp) addr_err++;
         rden_cnt++;
      end
      prev_rden = write_rom_ena_o;
      if (pll_scanclk_o === 1'b1 && prev_sclk === 1'b0) begin
         rise_cnt++;
         if (pll_scanclkena_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("scoreboard entry for scan bit", exp_q.size(), 1);
            end else begin
               check($sformatf("scandata bit %0d", pop_cnt), pll_scandata_o, exp_q.pop_front());
               pop_cnt++;
            end
         end
      end
      prev_sclk = pll_scanclk_o;
      if (pll_configupdate_o === 1'b1) begin
         cfg_cnt++;
         if (pll_scanclkena_o !== 1'b0) cfg_ena_err++;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_image();
      for (int i = 0; i < SCAN_BITS; i++) exp_q.push_back(pat(i));
   endtask

   task automatic clear_counts();
      rise_cnt    = 0;
      pop_cnt     = 0;
      rden_cnt    = 0;
      addr_err    = 0;
      cfg_cnt     = 0;
      cfg_ena_err = 0;
   endtask

   task automatic pulse(input logic wr, input logic rc, output int t0);
      tick();
      write_from_rom_i = wr;
      reconfig_i       = rc;
      t0               = cyc;
      tick();
      write_from_rom_i = 1'b0;
      reconfig_i       = 1'b0;
   endtask

   // Waits for busy to drop, playing the PLL: scandone rises once configupdate has ended.
   task automatic wait_idle(input int limit, output int len);
      bit saw_cfg;
      saw_cfg = 1'b0;
      len     = 0;
      while (busy_o === 1'b1 && len < limit) begin
         if (pll_configupdate_o === 1'b1) saw_cfg = 1'b1;
         else if (saw_cfg) pll_scandone_i = 1'b1;
         len++;
         tick();
      end
      pll_scandone_i = 1'b0;
      if (len >= limit) check("busy falls within budget", busy_o, 0);
   endtask

   typedef struct {
      logic wr;
      logic rc;
      int   busy_len;
      int   rises;
      int   rden;
      int   cfg;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int tx;
      int len;
      int n;
      int s;
      int busy_drop;

      // Busy lengths: load = SCAN_BITS+1; reconfig = 288 shift + 2 update
      // + 3 scandone latency + 2 areset (scandone raised as update ends).
      vecs[0] = '{1'b1, 1'b0, 145, 0,   144, 0};
      vecs[1] = '{1'b0, 1'b1, 295, 145, 0,   2};
      vecs[2] = '{1'b1, 1'b1, 145, 0,   144, 0};
      vecs[3] = '{1'b0, 1'b0, 0,   0,   0,   0};
      vecs[4] = '{1'b0, 1'b1, 295, 145, 0,   2};

      tick();
      tick();
      check("reset outputs", {busy_o, rom_address_o, write_rom_ena_o, pll_scanclk_o,
                              pll_scanclkena_o, pll_scandata_o, pll_configupdate_o, pll_areset_o}, 0);
      reset_i = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) begin
         clear_counts();
         if (vecs[i].rc && !vecs[i].wr) push_image();
         pulse(vecs[i].wr, vecs[i].rc, t0);
         check($sformatf("vec%0d busy after request", i), busy_o, (vecs[i].busy_len != 0));
         wait_idle(2000, len);
         check($sformatf("vec%0d busy length", i), len, vecs[i].busy_len);
         check($sformatf("vec%0d scanclk rises", i), rise_cnt, vecs[i].rises);
         check($sformatf("vec%0d rden cycles", i), rden_cnt, vecs[i].rden);
         check($sformatf("vec%0d rom address sequence errors", i), addr_err, 0);
         check($sformatf("vec%0d configupdate cycles", i), cfg_cnt, vecs[i].cfg);
         check($sformatf("vec%0d scanclkena during update", i), cfg_ena_err, 0);
         check($sformatf("vec%0d scoreboard drained", i), exp_q.size(), 0);
         if (vecs[i].wr) begin
            check($sformatf("vec%0d busy falls at T+146", i), cyc - t0, 146);
            check($sformatf("vec%0d rom address holds last", i), rom_address_o, SCAN_BITS - 1);
         end
      end

      // Update timing and a long scandone hold.
      clear_counts();
      push_image();
      pulse(1'b0, 1'b1, t0);
      n = 0;
      while (pll_configupdate_o !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      check("configupdate start after request", cyc - t0, 289);
      check("scanclkena low in update", pll_scanclkena_o, 0);
      tick();
      check("configupdate second cycle", pll_configupdate_o, 1);
      tick();
      check("configupdate drops after 2 cycles", pll_configupdate_o, 0);
      check("scanclk low while waiting", pll_scanclk_o, 0);
      busy_drop = 0;
      for (int i = 0; i < 500; i++) begin
         if (busy_o !== 1'b1 || pll_areset_o !== 1'b0) busy_drop++;
         tick();
      end
      check("busy held while scandone low", busy_drop, 0);
      pll_scandone_i = 1'b1;
      s = cyc;
      n = 0;
      while (pll_areset_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("areset starts 2..3 cycles after scandone", ((cyc - s) >= 2) && ((cyc - s) <= 3), 1);
      tick();
      check("areset second cycle", pll_areset_o, 1);
      check("busy during areset", busy_o, 1);
      tick();
      check("areset ends after 2 cycles", pll_areset_o, 0);
      check("busy falls after areset", busy_o, 0);
      pll_scandone_i = 1'b0;
      check("long-hold scoreboard drained", exp_q.size(), 0);

      // Reconfig during a load is dropped.
      clear_counts();
      pulse(1'b1, 1'b0, t0);
      repeat (40) tick();
      pulse(1'b0, 1'b1, tx);
      wait_idle(2000, len);
      check("mid-load reconfig: busy falls at T+146", cyc - t0, 146);
      check("mid-load reconfig: no scanclk", rise_cnt, 0);
      tick();
      check("mid-load reconfig: stays idle", busy_o, 0);

      // Asynchronous reset part-way through the shift.
      clear_counts();
      push_image();
      pulse(1'b0, 1'b1, t0);
      n = 0;
      while (pop_cnt < 70 && n < 1000) begin
         tick();
         n++;
      end
      check("reached scan bit 70", pop_cnt, 70);
      reset_i = 1'b1;
      #1;
      check("async reset clears outputs", {busy_o, rom_address_o, write_rom_ena_o, pll_scanclk_o,
                                           pll_scanclkena_o, pll_scandata_o, pll_configupdate_o,
                                           pll_areset_o}, 0);
      exp_q.delete();
      tick();
      tick();
      reset_i = 1'b0;
      tick();
      clear_counts();
      push_image();
      pulse(1'b0, 1'b1, t0);
      wait_idle(2000, len);
      check("post-reset reconfig busy length", len, 295);
      check("post-reset reconfig bits sent", pop_cnt, SCAN_BITS);
      check("post-reset scoreboard drained", exp_q.size(), 0);

      // Initiator handshake: write, idle cycle, wait, reconfig, wait.
      clear_counts();
      pulse(1'b1, 1'b0, t0);
      tick();
      wait_idle(1000, len);
      check("initiator load completes", busy_o, 0);
      push_image();
      pulse(1'b0, 1'b1, t0);
      wait_idle(2000, len);
      check("initiator reconfig completes", busy_o, 0);
      check("initiator bits sent", pop_cnt, SCAN_BITS);
      check("initiator scoreboard drained", exp_q.size(), 0);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
